// File: rtl/backoff_ctl.sv
// Slot-based random backoff engine for the CSMA/CA transmit path.
// Draws a slot count from the LFSR, waits out the IFS, then counts idle slots down.
module backoff_ctl #(
    parameter logic [15:0] LFSR_SEED = 16'hACE1,
    parameter int          CNT_WIDTH = 14
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic [3:0]           cw_exp,
    input  logic                 backoff_start,
    input  logic                 backoff_abort,
    input  logic                 ch_idle,
    input  logic [CNT_WIDTH-1:0] ifs_cycles,
    input  logic [CNT_WIDTH-1:0] slot_cycles,
    output logic                 backoff_done,
    output logic                 backoff_busy,
    output logic [15:0]          slots_left,
    output logic [1:0]           bo_state
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_IFS  = 2'd1,
        COUNTDOWN = 2'd2,
        DONE      = 2'd3
    } state_t;

    state_t                state_q, state_d;
    logic [15:0]           lfsr_q, lfsr_d;
    logic [15:0]           slots_q, slots_d;
    logic [CNT_WIDTH-1:0]  ifs_cnt_q, ifs_cnt_d;
    logic [CNT_WIDTH-1:0]  slot_cnt_q, slot_cnt_d;
    logic                  done_q, done_d;
    logic [15:0]           draw_mask;
    logic [15:0]           draw;

    // Fibonacci LFSR for x^16+x^14+x^13+x^11+1; free-running, never zero from a non-zero seed.
    assign lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};

    // Exponents of 15 and above saturate at the 15-bit window.
    assign draw_mask = (cw_exp >= 4'd15) ? 16'h7FFF : ((16'(1) << cw_exp) - 16'd1);
    assign draw      = {1'b0, lfsr_q[14:0]} & draw_mask;

    always_comb begin
        // NOTE: every signal gets a default first so no branch can leave one unassigned and infer a latch.
        state_d    = state_q;
        slots_d    = slots_q;
        ifs_cnt_d  = ifs_cnt_q;
        slot_cnt_d = slot_cnt_q;

        if (backoff_abort) begin
            state_d = IDLE;
            slots_d = '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (backoff_start) begin
                        state_d   = WAIT_IFS;
                        slots_d   = draw;
                        ifs_cnt_d = ifs_cycles;
                    end
                end
                WAIT_IFS: begin
                    if (!ch_idle) begin
                        ifs_cnt_d = ifs_cycles;
                    end else if (ifs_cnt_q <= CNT_WIDTH'(1)) begin
                        if (slots_q == 16'd0) begin
                            state_d = DONE;
                        end else begin
                            state_d    = COUNTDOWN;
                            slot_cnt_d = slot_cycles;
                        end
                    end else begin
                        ifs_cnt_d = ifs_cnt_q - CNT_WIDTH'(1);
                    end
                end
                COUNTDOWN: begin
                    // A busy medium discards the partial slot and demands a full IFS again.
                    if (!ch_idle) begin
                        state_d   = WAIT_IFS;
                        ifs_cnt_d = ifs_cycles;
                    end else if (slot_cnt_q <= CNT_WIDTH'(1)) begin
                        slot_cnt_d = slot_cycles;
                        if (slots_q != 16'd0) begin
                            slots_d = slots_q - 16'd1;
                        end
                        if (slots_q <= 16'd1) begin
                            state_d = DONE;
                        end
                    end else begin
                        slot_cnt_d = slot_cnt_q - CNT_WIDTH'(1);
                    end
                end
                DONE: begin
                    state_d = IDLE;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    // The done flag is registered alongside the state so it is high exactly while state is DONE.
    assign done_d = (state_d == DONE);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q    <= IDLE;
            lfsr_q     <= LFSR_SEED;
            slots_q    <= '0;
            ifs_cnt_q  <= '0;
            slot_cnt_q <= '0;
            done_q     <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values regardless of statement order.
            state_q    <= state_d;
            lfsr_q     <= lfsr_d;
            slots_q    <= slots_d;
            ifs_cnt_q  <= ifs_cnt_d;
            slot_cnt_q <= slot_cnt_d;
            done_q     <= done_d;
        end
    end

    assign backoff_done = done_q;
    assign backoff_busy = (state_q != IDLE);
    assign slots_left   = slots_q;
    assign bo_state     = state_q;

endmodule

// File: tb/tb_backoff_ctl.sv
// Self-checking bench for backoff_ctl: directed scenarios with literal expectations
// plus randomized traffic, all compared every cycle against a behavioural model.
module tb_backoff_ctl;

    localparam int CW = 14;

    logic          clk = 1'b0;
    logic          rstn;
    logic [3:0]    cw_exp;
    logic          backoff_start;
    logic          backoff_abort;
    logic          ch_idle;
    logic [CW-1:0] ifs_cycles;
    logic [CW-1:0] slot_cycles;
    logic          backoff_done;
    logic          backoff_busy;
    logic [15:0]   slots_left;
    logic [1:0]    bo_state;

    int n_cmp = 0;
    int n_err = 0;

    backoff_ctl #(.LFSR_SEED(16'hACE1), .CNT_WIDTH(CW)) dut (
        .clk          (clk),
        .rstn         (rstn),
        .cw_exp       (cw_exp),
        .backoff_start(backoff_start),
        .backoff_abort(backoff_abort),
        .ch_idle      (ch_idle),
        .ifs_cycles   (ifs_cycles),
        .slot_cycles  (slot_cycles),
        .backoff_done (backoff_done),
        .backoff_busy (backoff_busy),
        .slots_left   (slots_left),
        .bo_state     (bo_state)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Phase numbers follow the published bo_state encoding; waiting is modelled as
    // "idle cycles seen so far" against a cycle requirement latched at each (re)load.
    localparam int P_IDLE = 0, P_IFS = 1, P_CD = 2, P_DONE = 3;

    int          m_phase;
    int          m_seen;
    int          m_need;
    logic [15:0] m_slots;
    logic [15:0] m_lfsr;

    function automatic logic [15:0] lfsr_step(input logic [15:0] x);
        int fb;
        fb = ((x >> 15) ^ (x >> 13) ^ (x >> 12) ^ (x >> 10)) & 1;
        return 16'(((32'(x) << 1) | fb) & 32'hFFFF);
    endfunction

    function automatic logic [15:0] draw_of(input logic [15:0] l, input int e);
        int window;
        window = 1 << ((e > 15) ? 15 : e);
        return 16'((int'(l) % 32768) % window);
    endfunction

    function automatic int at_least_one(input int v);
        return (v < 1) ? 1 : v;
    endfunction

    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            m_phase <= P_IDLE;
            m_seen  <= 0;
            m_need  <= 1;
            m_slots <= '0;
            m_lfsr  <= 16'hACE1;
        end else begin
            m_lfsr <= lfsr_step(m_lfsr);
            if (backoff_abort) begin
                m_phase <= P_IDLE;
                m_slots <= '0;
            end else if (m_phase == P_IDLE) begin
                if (backoff_start) begin
                    m_phase <= P_IFS;
                    m_slots <= draw_of(m_lfsr, int'(cw_exp));
                    m_seen  <= 0;
                    m_need  <= at_least_one(int'(ifs_cycles));
                end
            end else if (m_phase == P_IFS) begin
                if (!ch_idle) begin
                    m_seen <= 0;
                    m_need <= at_least_one(int'(ifs_cycles));
                end else if (m_seen + 1 >= m_need) begin
                    m_seen <= 0;
                    if (m_slots == 0) m_phase <= P_DONE;
                    else begin
                        m_phase <= P_CD;
                        m_need  <= at_least_one(int'(slot_cycles));
                    end
                end else m_seen <= m_seen + 1;
            end else if (m_phase == P_CD) begin
                if (!ch_idle) begin
                    m_phase <= P_IFS;
                    m_seen  <= 0;
                    m_need  <= at_least_one(int'(ifs_cycles));
                end else if (m_seen + 1 >= m_need) begin
                    m_seen  <= 0;
                    m_need  <= at_least_one(int'(slot_cycles));
                    m_slots <= m_slots - 16'd1;
                    if (m_slots == 16'd1) m_phase <= P_DONE;
                end else m_seen <= m_seen + 1;
            end else begin
                m_phase <= P_IDLE;
            end
        end
    end

    // Single compare process: outputs are registered, so checking on the falling edge is race-free.
    always @(negedge clk) begin
        check("state", 32'(bo_state), 32'(m_phase));
        check("busy", 32'(backoff_busy), 32'(m_phase != P_IDLE));
        check("done", 32'(backoff_done), 32'(m_phase == P_DONE));
        check("slots_left", 32'(slots_left), 32'(m_slots));
    end

    // ---------------- stimulus helpers ----------------
    task automatic edge_n(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rstn = 1'b0;
        edge_n(2);
        rstn = 1'b1;
    endtask

    task automatic start_bo(input logic [3:0] e);
        cw_exp        = e;
        backoff_start = 1'b1;
        edge_n(1);
        backoff_start = 1'b0;
    endtask

    task automatic wait_done(input int budget, output int edges);
        edges = 0;
        while (!backoff_done && edges < budget) begin
            edge_n(1);
            edges++;
        end
        if (!backoff_done) check("done_timeout", 32'(0), 32'(1));
    endtask

    task automatic wait_state(input logic [1:0] s, input int budget, output int edges);
        edges = 0;
        while (bo_state != s && edges < budget) begin
            edge_n(1);
            edges++;
        end
        if (bo_state != s) check("state_timeout", 32'(bo_state), 32'(s));
    endtask

    task automatic wait_draw_at_least(input int lo);
        int guard = 0;
        while (int'(m_lfsr & 16'hF) < lo && guard < 200) begin
            edge_n(1);
            guard++;
        end
    endtask

    initial begin
        int e;
        int s_hold;

        rstn          = 1'b0;
        cw_exp        = '0;
        backoff_start = 1'b0;
        backoff_abort = 1'b0;
        ch_idle       = 1'b1;
        ifs_cycles    = CW'(34);
        slot_cycles   = CW'(9);
        #1;
        check("reset_state", 32'(bo_state), 32'(0));
        check("reset_slots", 32'(slots_left), 32'(0));

        // cw_exp=0: 34 IFS cycles, then DONE; 36 cycles counting the start cycle.
        do_reset();
        start_bo(4'd0);
        wait_done(200, e);
        check("cw0_latency", 32'(e + 2), 32'(36));
        edge_n(1);

        // First cycle after reset uses the seed: 0xACE1 & 0xF = 1 slot, 1+34+9+1 = 45 cycles.
        do_reset();
        start_bo(4'd4);
        check("seed_draw", 32'(slots_left), 32'(1));
        wait_done(300, e);
        check("cw4_latency", 32'(e + 2), 32'(45));
        edge_n(1);

        // Busy medium mid-COUNTDOWN at 5 slots left: freeze, then full IFS plus 5 slots.
        wait_draw_at_least(6);
        start_bo(4'd4);
        e = 0;
        while (!(slots_left == 16'd5 && bo_state == 2'd2) && e < 400) begin
            edge_n(1);
            e++;
        end
        check("reach_slots5", 32'(slots_left), 32'(5));
        edge_n(3);
        ch_idle = 1'b0;
        edge_n(20);
        check("frozen_state", 32'(bo_state), 32'(1));
        check("frozen_slots", 32'(slots_left), 32'(5));
        ch_idle = 1'b1;
        wait_done(300, e);
        check("resume_latency", 32'(e), 32'(34 + 5 * 9));
        edge_n(1);

        // Busy on the last IFS cycle restarts the full 34-cycle wait.
        wait_draw_at_least(1);
        start_bo(4'd4);
        edge_n(33);
        check("last_ifs_state", 32'(bo_state), 32'(1));
        ch_idle = 1'b0;
        edge_n(1);
        ch_idle = 1'b1;
        wait_state(2'd2, 100, e);
        check("ifs_restart", 32'(e), 32'(34));

        // Abort inside COUNTDOWN.
        edge_n(2);
        backoff_abort = 1'b1;
        edge_n(1);
        backoff_abort = 1'b0;
        check("abort_cd_state", 32'(bo_state), 32'(0));
        check("abort_cd_busy", 32'(backoff_busy), 32'(0));
        check("abort_cd_slots", 32'(slots_left), 32'(0));
        check("abort_cd_done", 32'(backoff_done), 32'(0));

        // Abort together with start in IDLE wins.
        backoff_abort = 1'b1;
        backoff_start = 1'b1;
        edge_n(1);
        backoff_abort = 1'b0;
        backoff_start = 1'b0;
        check("abort_start_state", 32'(bo_state), 32'(0));
        check("abort_start_slots", 32'(slots_left), 32'(0));

        // Start while counting down is ignored.
        wait_draw_at_least(2);
        start_bo(4'd4);
        wait_state(2'd2, 100, e);
        edge_n(1);
        s_hold = int'(slots_left);
        backoff_start = 1'b1;
        edge_n(1);
        backoff_start = 1'b0;
        check("start_in_cd_state", 32'(bo_state), 32'(2));
        check("start_in_cd_slots", 32'(slots_left), 32'(s_hold));
        backoff_abort = 1'b1;
        edge_n(1);
        backoff_abort = 1'b0;

        // Async reset in WAIT_IFS clears outputs at once and reseeds the LFSR.
        start_bo(4'd15);
        edge_n(5);
        check("pre_reset_state", 32'(bo_state), 32'(1));
        rstn = 1'b0;
        #1;
        check("async_rst_state", 32'(bo_state), 32'(0));
        check("async_rst_busy", 32'(backoff_busy), 32'(0));
        check("async_rst_slots", 32'(slots_left), 32'(0));
        edge_n(2);
        rstn = 1'b1;
        start_bo(4'd15);
        check("reseed_draw", 32'(slots_left), 32'(16'h2CE1));
        backoff_abort = 1'b1;
        edge_n(1);
        backoff_abort = 1'b0;

        // Randomized traffic, every cycle compared against the model.
        for (int i = 0; i < 3000; i++) begin
            cw_exp        = 4'($urandom_range(0, 5));
            ifs_cycles    = CW'($urandom_range(0, 5));
            slot_cycles   = CW'($urandom_range(0, 3));
            ch_idle       = ($urandom_range(0, 7) != 0);
            backoff_start = ($urandom_range(0, 5) == 0);
            backoff_abort = ($urandom_range(0, 63) == 0);
            edge_n(1);
        end
        backoff_start = 1'b0;
        backoff_abort = 1'b0;
        edge_n(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/backoff_ctl.md
Name: backoff_ctl

Overview:
Slot-based random backoff engine for the CSMA/CA transmit path, and the consumer of the contention-window exponent produced by the cw_exp block. On a start request it draws a random slot count uniformly from [0, 2^cw_exp - 1] and waits for the channel to be idle for the IFS time. It then counts slots down while the channel stays idle, freezing on busy, and signals the tx path when the medium may be taken.

Parameters:
LFSR_SEED, 16'hACE1, non-zero reset value of the 16-bit Fibonacci LFSR
CNT_WIDTH, 14, width of the IFS and slot cycle counters

Ports:
clk  in  1  system clock
rstn  in  1  asynchronous active-low reset
cw_exp  in  4  contention-window exponent, sampled on accepted backoff_start
backoff_start  in  1  single-cycle request to begin a new backoff
backoff_abort  in  1  single-cycle cancel; returns block to IDLE
ch_idle  in  1  1 = medium idle (CCA clear and NAV zero)
ifs_cycles  in  CNT_WIDTH  DIFS/AIFS length in clk cycles, sampled continuously
slot_cycles  in  CNT_WIDTH  slot length in clk cycles, sampled continuously
backoff_done  out  1  one-cycle pulse: backoff finished, tx may start
backoff_busy  out  1  1 while state is not IDLE
slots_left  out  16  remaining backoff slots (debug/status)
bo_state  out  2  current state encoding: IDLE=0, WAIT_IFS=1, COUNTDOWN=2, DONE=3

Behaviour:
- Reset (async, rstn=0): state IDLE, backoff_done=0, backoff_busy=0, slots_left=0, all counters 0, LFSR=LFSR_SEED.
- LFSR: 16-bit, taps x^16+x^14+x^13+x^11+1, advances every clk cycle out of reset regardless of state. It never reaches zero.
- Draw: slots = {1'b0, lfsr[14:0]} & ((1<<cw_exp)-1).
  - cw_exp=0 gives 0.
  - cw_exp>=15 gives the 15-bit mask 0x7FFF.
- IDLE: backoff_start=1 and backoff_abort=0 → next cycle WAIT_IFS, slots_left=draw, ifs_cnt=ifs_cycles.
- WAIT_IFS:
  - ch_idle=0: ifs_cnt reloads ifs_cycles; stay.
  - ch_idle=1 and ifs_cnt<=1: leave. If slots_left==0, go to DONE. Otherwise go to COUNTDOWN with slot_cnt=slot_cycles.
  - ch_idle=1 otherwise: ifs_cnt decrements.
  - With a continuously idle medium, WAIT_IFS lasts max(ifs_cycles,1) cycles.
- COUNTDOWN:
  - ch_idle=0: go to WAIT_IFS, ifs_cnt=ifs_cycles, slots_left frozen (not decremented; the partial slot is lost).
  - ch_idle=1 and slot_cnt<=1: slots_left decrements and slot_cnt reloads. If slots_left was 1, go to DONE.
  - ch_idle=1 otherwise: slot_cnt decrements.
  - Each slot costs max(slot_cycles,1) idle cycles.
- DONE: backoff_done=1 for exactly this one cycle, then IDLE unconditionally. The ch_idle value in DONE is ignored; the tx path owns the medium from here.
- backoff_done is a registered decode of state==DONE. It is never asserted in any other state.
- backoff_abort has priority over every other input in every state: next cycle IDLE, slots_left=0, no done pulse. Abort in the DONE cycle does not suppress the already-asserted pulse.
- backoff_start is ignored when the state is not IDLE, including DONE. A new backoff needs a fresh start after returning to IDLE.
- cw_exp, ifs_cycles and slot_cycles changing mid-operation:
  - cw_exp only matters at the draw.
  - ifs_cycles and slot_cycles take effect at the next reload.
- slots_left never underflows. The decrement only happens when the value is >=1.
- Async reset asserted mid-operation returns all state immediately; no pulse is emitted.

Test Plan:
- Reset, then start with cw_exp=0, ifs_cycles=34, slot_cycles=9, ch_idle=1 → WAIT_IFS for 34 cycles, DONE, backoff_done one cycle high exactly 36 cycles after the start cycle, slots_left=0 throughout.
- Force the LFSR draw via a known seed with cw_exp=4 and the bench-model draw D → done after 1+34+9*D+1 cycles; slots_left steps down by 1 every 9 cycles and stays within 0..15.
- Drop ch_idle for 20 cycles mid-COUNTDOWN at slots_left=5 → state WAIT_IFS, slots_left holds 5, after idle returns a full 34-cycle IFS then 5 full slots before done.
- Toggle ch_idle low on the last WAIT_IFS cycle → ifs_cnt reloads; COUNTDOWN not entered until 34 consecutive idle cycles are seen.
- Assert backoff_abort in COUNTDOWN, and separately together with backoff_start in IDLE → IDLE next cycle, no backoff_done, busy=0, slots_left=0.
- Assert backoff_start during COUNTDOWN; deassert rstn mid-WAIT_IFS → start ignored (slots_left unchanged); on reset, outputs zero asynchronously and LFSR returns to LFSR_SEED.
